// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arbState;

  typedef enum logic {
    GNT_I,
    GNT_D
  } arbGrant;

  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of data grants won while fetch was waiting; bounds fetch starvation.
module arb_streak_counter #(
  parameter int MAX_D_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic atMax
);

  localparam int CW = $clog2(MAX_D_BURST + 1);

  logic [CW-1:0] streak;

  function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
    return (v == CW'(MAX_D_BURST)) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) streak <= '0;
    else if (clr) streak <= '0;
    else if (inc) streak <= satInc(streak);
  end

  assign atMax = (streak == CW'(MAX_D_BURST));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one variable-latency memory port between fetch and data (data has priority).
// Define MEM_TIMEOUT_EN to abort accesses that see no mem_ack within TIMEOUT cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_D_BURST = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  output logic                  if_err,
  output logic                  stall_f,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_be,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  d_err,
  output logic                  stall_m,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  arbState state, stateNext;
  arbGrant grant;
  logic    ifPend, dPend, grantValid, atMax;
  logic    finish, abort, timeoutHit;

  // A port whose ready is high still holds req for the access just completed.
  assign ifPend     = if_req & ~if_ready;
  assign dPend      = d_req & ~d_ready;
  assign stall_f    = ifPend;
  assign stall_m    = dPend;
  assign grantValid = (state == IDLE) && (ifPend || dPend);
  assign grant      = (dPend && !(ifPend && atMax)) ? GNT_D : GNT_I;

  arb_streak_counter #(
    .MAX_D_BURST(MAX_D_BURST)
  ) uStreak (
    .clk  (clk),
    .rst  (rst),
    .inc  (grantValid && (grant == GNT_D) && ifPend),
    .clr  (grantValid && (grant == GNT_I)),
    .atMax(atMax)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] busyCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busyCnt <= '0;
    else if (state == IDLE) busyCnt <= '0;
    else busyCnt <= busyCnt + 1'b1;
  end

  assign timeoutHit = (busyCnt == TW'(TIMEOUT - 1));
`else
  logic unusedTimeout;
  assign unusedTimeout = (TIMEOUT > 0);
  assign timeoutHit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= stateNext;
  end

  // An ack on the limit edge wins over the timeout.
  always_comb begin
    stateNext = state;
    finish    = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: begin
        if (grantValid) stateNext = (grant == GNT_D) ? BUSY_D : BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          finish    = 1'b1;
          stateNext = IDLE;
        end else if (timeoutHit) begin
          finish    = 1'b1;
          abort     = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_ready <= finish && (state == BUSY_I);
      d_ready  <= finish && (state == BUSY_D);
      if (grantValid) begin
        mem_req <= 1'b1;
        if (grant == GNT_D) begin
          mem_we    <= d_we;
          mem_be    <= d_be;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end else begin
          mem_we    <= 1'b0;
          mem_be    <= BE_WORD;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end
      end else if (finish) begin
        mem_req <= 1'b0;
      end
      if (finish && (state == BUSY_I)) if_rdata <= abort ? '0 : mem_rdata;
      if (finish && (state == BUSY_D)) d_rdata <= abort ? '0 : mem_rdata;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_err <= 1'b0;
      d_err  <= 1'b0;
    end else begin
      if_err <= abort && (state == BUSY_I);
      d_err  <= abort && (state == BUSY_D);
    end
  end
`else
  assign if_err = 1'b0;
  assign d_err  = 1'b0;
`endif

endmodule
